// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-master arbiter for the single-port data memory. Fixed m0 priority with an aging
// override for m1. Accesses are registered onto mem_* for one cycle, and load data returns one cycle later.
module dmem_arbiter #(
    parameter int ADDR_W   = 7,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_err,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_err,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_write,
    output logic              mem_read,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);
    typedef enum logic {IDLE, ACCESS} state_t;
    state_t     state, state_nxt;
    logic       el0, el1, win0, win1, we_r, al_r;
    logic [3:0] wait_cnt;
    always_comb begin
        el0       = m0_req & ~m0_gnt;
        el1       = m1_req & ~m1_gnt;
        win1      = el1 & ((wait_cnt == 4'(MAX_WAIT)) | ~el0);
        win0      = el0 & ~win1;
        state_nxt = (win0 | win1) ? ACCESS : IDLE;
    end
    always_ff @(posedge clock or posedge reset)
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    // Strobes come straight from state so an asynchronous reset kills them within the cycle.
    always_comb begin
        mem_write = (state == ACCESS) & we_r & al_r;
        mem_read  = (state == ACCESS) & ~we_r & al_r;
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            m0_gnt    <= 1'b0;
            m1_gnt    <= 1'b0;
            m0_err    <= 1'b0;
            m1_err    <= 1'b0;
            m0_rvalid <= 1'b0;
            m1_rvalid <= 1'b0;
            m0_rdata  <= '0;
            m1_rdata  <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            we_r      <= 1'b0;
            al_r      <= 1'b0;
            wait_cnt  <= '0;
        end else begin
            m0_gnt    <= win0;
            m1_gnt    <= win1;
            m0_err    <= win0 & (m0_addr[1:0] != 2'b00);
            m1_err    <= win1 & (m1_addr[1:0] != 2'b00);
            m0_rvalid <= m0_gnt & mem_read;
            m1_rvalid <= m1_gnt & mem_read;
            if (m0_gnt & mem_read) m0_rdata <= mem_rdata;
            if (m1_gnt & mem_read) m1_rdata <= mem_rdata;
            if (win0 | win1) begin
                mem_addr  <= win1 ? m1_addr : m0_addr;
                mem_wdata <= win1 ? m1_wdata : m0_wdata;
                we_r      <= win1 ? m1_we : m0_we;
                al_r      <= win1 ? (m1_addr[1:0] == 2'b00) : (m0_addr[1:0] == 2'b00);
            end
            wait_cnt <= win1 ? 4'd0 :
                        (el1 && wait_cnt != 4'(MAX_WAIT)) ? wait_cnt + 4'd1 : wait_cnt;
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed and randomized checks of dmem_arbiter against a cycle-level reference model,
// with a behavioural 32-word memory attached to the mem_* port.
module tb_dmem_arbiter;
    localparam int AW = 7, DW = 32, MW = 4;
    logic clock = 1'b0, reset = 1'b1;
    logic m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0;
    logic [AW-1:0] m0_addr = '0, m1_addr = '0, mem_addr;
    logic [DW-1:0] m0_wdata = '0, m1_wdata = '0, m0_rdata, m1_rdata, mem_wdata, mem_rdata = '0;
    logic m0_gnt, m0_err, m0_rvalid, m1_gnt, m1_err, m1_rvalid, mem_write, mem_read;
    int n_chk = 0, n_pass = 0, n_fail = 0;

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW)) dut (
        .clock(clock), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_err(m0_err), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_err(m1_err), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .mem_addr(mem_addr), .mem_write(mem_write), .mem_read(mem_read),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clock = ~clock;

    logic [DW-1:0] mem_arr [32];
    always @(posedge clock) if (mem_write) mem_arr[mem_addr[6:2]] <= mem_wdata;
    always @(negedge clock) if (mem_read) mem_rdata <= mem_arr[mem_addr[6:2]];

    // Reference model: what the block should present in the cycle after each edge.
    logic [DW-1:0] ref_mem [32];
    logic [1:0]    e_gnt, e_err, e_rv;
    logic [DW-1:0] e_rd [2];
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wd;
    logic          e_we, e_al, e_act;
    int            e_wait;

    task automatic mdl_reset();
        e_gnt = 0; e_err = 0; e_rv = 0; e_rd[0] = 0; e_rd[1] = 0;
        e_addr = 0; e_wd = 0; e_we = 0; e_al = 0; e_act = 0; e_wait = 0;
    endtask

    task automatic predict();
        logic [1:0] el, rv;
        logic w0, w1;
        int own;
        rv = 0;
        if (e_act && e_al) begin
            own = int'(e_gnt[1]);
            if (e_we) ref_mem[e_addr[6:2]] = e_wd;
            else begin e_rd[own] = ref_mem[e_addr[6:2]]; rv[own] = 1'b1; end
        end
        el = {m1_req & ~e_gnt[1], m0_req & ~e_gnt[0]};
        w1 = el[1] && (e_wait == MW || !el[0]);
        w0 = el[0] && !w1;
        e_wait = w1 ? 0 : el[1] ? ((e_wait < MW) ? e_wait + 1 : MW) : e_wait;
        if (w1) begin e_addr = m1_addr; e_wd = m1_wdata; e_we = m1_we; end
        else if (w0) begin e_addr = m0_addr; e_wd = m0_wdata; e_we = m0_we; end
        if (w0 | w1) e_al = (e_addr[1:0] == 2'b00);
        e_act = w0 | w1;
        e_gnt = {w1, w0};
        e_err = e_gnt & {2{~e_al}};
        e_rv  = rv;
    endtask

    function automatic logic [127:0] obs();
        return 128'({m0_gnt, m1_gnt, m0_err, m1_err, m0_rvalid, m1_rvalid, mem_write, mem_read,
                     mem_addr, mem_wdata, m0_rdata, m1_rdata});
    endfunction

    function automatic logic [127:0] expv();
        return 128'({e_gnt[0], e_gnt[1], e_err[0], e_err[1], e_rv[0], e_rv[1],
                     e_act & e_we & e_al, e_act & ~e_we & e_al, e_addr, e_wd, e_rd[0], e_rd[1]});
    endfunction

    task automatic check(input string tag, input logic [127:0] o, input logic [127:0] e);
        n_chk++;
        assert (o === e) n_pass++;
        else begin n_fail++; $error("FAIL %s: got %h expected %h", tag, o, e); end
    endtask

    task automatic tick(input string tag);
        predict();
        @(posedge clock);
        #1;
        check(tag, obs(), expv());
    endtask

    task automatic idle(input int n);
        m0_req = 0; m1_req = 0;
        for (int i = 0; i < n; i++) tick("idle");
    endtask

    task automatic rand_drive();
        if (!(m0_req && !e_gnt[0])) begin
            m0_req = ($urandom_range(0, 3) != 0); m0_we = 1'($urandom_range(0, 1)); m0_wdata = $urandom;
            m0_addr = 7'($urandom_range(0, 7) * 4 + (($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : 0));
        end
        if (!(m1_req && !e_gnt[1])) begin
            m1_req = ($urandom_range(0, 3) != 0); m1_we = 1'($urandom_range(0, 1)); m1_wdata = $urandom;
            m1_addr = 7'($urandom_range(0, 7) * 4 + (($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : 0));
        end
    endtask

    initial begin
        int n_rd, elig, bad;
        for (int i = 0; i < 32; i++) begin mem_arr[i] = 32'(i + 5); ref_mem[i] = 32'(i + 5); end
        mdl_reset();
        #12;
        check("reset_outputs", obs(), 128'(0));
        @(posedge clock); #1 reset = 0;

        // store then load on m0
        m0_req = 1; m0_we = 1; m0_addr = 7'h08; m0_wdata = 32'hDEADBEEF;
        tick("st_gnt");
        m0_req = 0;
        tick("st_done");
        m0_req = 1; m0_we = 0;
        tick("ld_gnt");
        m0_req = 0;
        tick("ld_rvalid");
        check("ld_data", 128'({m0_rvalid, m0_rdata}), 128'({1'b1, 32'hDEADBEEF}));
        check("mem2_written", 128'(mem_arr[2]), 128'(32'hDEADBEEF));
        idle(1);

        // both masters hammer loads: grants alternate
        m0_req = 1; m0_we = 0; m0_addr = 7'h00; m1_req = 1; m1_we = 0; m1_addr = 7'h04;
        n_rd = 0;
        for (int i = 0; i < 8; i++) begin
            tick("alt");
            check("alt_order", 128'({m0_gnt, m1_gnt}), 128'((i % 2 == 0) ? 2'b10 : 2'b01));
            n_rd += int'(mem_read);
        end
        check("alt_reads", 128'(n_rd), 128'(8));
        idle(2);
        check("alt_rdata", 128'({m0_rdata, m1_rdata}), 128'({32'd5, 32'd6}));

        // m1 only requests when m0 is also eligible: aging must let m1 in on its 5th try
        m0_req = 1; m0_addr = 7'h00; m1_addr = 7'h04; elig = 0;
        for (int i = 0; i < 12; i++) begin
            m1_req = !e_gnt[0];
            if (m1_req && !e_gnt[1]) elig++;
            tick("age");
            if (m1_gnt) break;
        end
        check("age_gnt", 128'({m1_gnt, 4'(elig)}), 128'({1'b1, 4'd5}));
        idle(2);

        // misaligned m1 store
        m1_req = 1; m1_we = 1; m1_addr = 7'h05; m1_wdata = 32'hFFFFFFFF;
        tick("mis_gnt");
        check("mis_flags", 128'({m1_gnt, m1_err, mem_write}), 128'(3'b110));
        idle(2);
        check("mis_mem", 128'(mem_arr[1]), 128'(32'd6));

        // m0 store and m1 load to the same word on the same edge
        m0_req = 1; m0_we = 1; m0_addr = 7'h0C; m0_wdata = 32'h12345678;
        m1_req = 1; m1_we = 0; m1_addr = 7'h0C;
        tick("haz_m0");
        m0_req = 0;
        tick("haz_m1");
        m1_req = 0;
        tick("haz_rv");
        check("haz_rdata", 128'({m1_rvalid, m1_rdata}), 128'({1'b1, 32'h12345678}));
        idle(1);

        // reset in the middle of an m1 store access
        m1_req = 1; m1_we = 1; m1_addr = 7'h10; m1_wdata = 32'hAAAA5555;
        tick("rst_gnt");
        m1_req = 0;
        #3 reset = 1;
        #1 check("rst_outputs", obs(), 128'(0));
        mdl_reset();
        @(posedge clock); #1 reset = 0;
        check("rst_mem", 128'(mem_arr[4]), 128'(32'd9));

        for (int i = 0; i < 400; i++) begin
            rand_drive();
            tick("rand");
        end
        idle(3);
        bad = 0;
        for (int i = 0; i < 32; i++) if (mem_arr[i] !== ref_mem[i]) bad++;
        check("mem_final", 128'(bad), 128'(0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
